// File: rtl/cache_arbiter.sv
// Two-port arbiter between the I-cache and D-cache miss ports and a single
// shared cacheline memory port; alternates grants under contention.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } state_t;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(31);

  state_t              r_state;
  state_t              w_next;
  logic                r_last_d;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic [LINE_W-1:0]   r_i_line;
  logic [LINE_W-1:0]   r_d_line;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Under contention the port that did not win last time gets the grant.
  assign w_grant_i = (r_state == IDLE) & w_i_req & (~w_d_req | r_last_d);
  assign w_grant_d = (r_state == IDLE) & w_d_req & (~w_i_req | ~r_last_d);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: the next-state value gets a default first so no path through the
  // case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_next = SERVE_I;
        end else if (w_grant_d) begin
          w_next = SERVE_D;
        end
      end
      SERVE_I: if (mem_resp) w_next = RESP_I;
      SERVE_D: if (mem_resp) w_next = RESP_D;
      RESP_I:  w_next = IDLE;
      RESP_D:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    i_resp = 1'b0;
    d_resp = 1'b0;
    case (r_state)
      RESP_I:  i_resp = 1'b1;
      RESP_D:  d_resp = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the line buffers are plain registers, so they are cleared by reset
  // like any other state; nothing here is a RAM macro that cannot be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_i_line      <= '0;
      r_d_line      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_last_d      <= 1'b0;
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_address <= i_address & ~OFFSET_MASK;
          end else if (w_grant_d) begin
            r_last_d      <= 1'b1;
            r_mem_read    <= d_read & ~d_write;
            r_mem_write   <= d_write;
            r_mem_address <= d_address & ~OFFSET_MASK;
            r_mem_wdata   <= d_wdata;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_line    <= mem_rdata;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            // A writeback completion carries no line, so the buffer keeps its value.
            if (r_mem_read) begin
              r_d_line <= mem_rdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign i_rdata     = r_i_line;
  assign d_rdata     = r_d_line;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed transactions, a transaction-level
// reference model compared every cycle, and literal spot checks.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding line transaction, a response slot,
  // and a record of which port won most recently.
  logic              m_active, m_port_d, m_wr, m_resp_i, m_resp_d, m_last_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata, m_i_line, m_d_line;

  function automatic logic pick_d(input logic want_i, input logic want_d, input logic last_d);
    return want_d && !(want_i && last_d);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_port_d <= 0; m_wr <= 0; m_resp_i <= 0; m_resp_d <= 0;
      m_last_d <= 0; m_addr <= '0; m_wdata <= '0; m_i_line <= '0; m_d_line <= '0;
    end else if (m_resp_i || m_resp_d) begin
      m_resp_i <= 0;
      m_resp_d <= 0;
    end else if (m_active) begin
      if (mem_resp) begin
        m_active <= 0;
        if (!m_wr && m_port_d)  m_d_line <= mem_rdata;
        if (!m_wr && !m_port_d) m_i_line <= mem_rdata;
        m_resp_d <= m_port_d;
        m_resp_i <= !m_port_d;
      end
    end else if (i_read || d_read || d_write) begin
      m_active <= 1;
      if (pick_d(i_read, d_read | d_write, m_last_d)) begin
        m_port_d <= 1; m_last_d <= 1; m_wr <= d_write;
        m_addr   <= {d_address[ADDR_W-1:5], 5'b0};
        m_wdata  <= d_wdata;
      end else begin
        m_port_d <= 0; m_last_d <= 0; m_wr <= 0;
        m_addr   <= {i_address[ADDR_W-1:5], 5'b0};
      end
    end
  end

  always @(negedge clk) begin
    check("i_resp",      i_resp,      m_resp_i);
    check("d_resp",      d_resp,      m_resp_d);
    check("mem_read",    mem_read,    m_active & ~m_wr);
    check("mem_write",   mem_write,   m_active & m_wr);
    check("mem_address", mem_address, m_addr);
    check("mem_wdata",   mem_wdata,   m_wdata);
    check("i_rdata",     i_rdata,     m_i_line);
    check("d_rdata",     d_rdata,     m_d_line);
    check("resp_excl",   i_resp & d_resp, 1'b0);
    check("strobe_excl", mem_read & mem_write, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 20 && !(mem_read || mem_write); n++) tick();
    check("grant_wait", mem_read | mem_write, 1'b1);
  endtask

  // Hold the strobe for lat cycles (counting the current one), answering in the last.
  task automatic respond(input int lat, input logic [LINE_W-1:0] data);
    repeat (lat - 1) tick();
    mem_rdata = data;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_mem_read",  mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_i_resp",    i_resp, 1'b0);
    check("rst_d_rdata",   d_rdata, '0);
    rst_n = 1'b1;
    tick();

    // Single I miss, 3-cycle memory latency
    i_read = 1'b1; i_address = 32'h0000_1234;
    tick();
    check("imiss_strobe", mem_read, 1'b1);
    check("imiss_addr",   mem_address, 32'h0000_1220);
    respond(3, {32{8'hA5}});
    check("imiss_resp_c4", i_resp, 1'b1);
    check("imiss_rdata",   i_rdata, {32{8'hA5}});
    check("imiss_strobe_low", mem_read, 1'b0);
    i_read = 1'b0;
    tick();
    check("imiss_one_pulse", i_resp, 1'b0);
    tick();

    // D writeback then read of the same line
    d_write = 1'b1; d_address = 32'h0000_5678; d_wdata = {64{4'h1}};
    wait_grant();
    check("dwr_write", mem_write, 1'b1);
    check("dwr_read",  mem_read, 1'b0);
    check("dwr_wdata", mem_wdata, {64{4'h1}});
    respond(2, {32{8'h3C}});
    check("dwr_resp",      d_resp, 1'b1);
    check("dwr_rdata_kept", d_rdata, '0);
    d_write = 1'b0;
    tick();
    d_read = 1'b1;
    wait_grant();
    check("drd_read",  mem_read, 1'b1);
    check("drd_write", mem_write, 1'b0);
    check("drd_addr",  mem_address, 32'h0000_5660);
    respond(1, {32{8'h5A}});
    check("drd_resp_min_latency", d_resp, 1'b1);
    check("drd_rdata", d_rdata, {32{8'h5A}});
    d_read = 1'b0;
    tick();

    // Async reset in the middle of a writeback
    d_write = 1'b1; d_address = 32'h0000_9000; d_wdata = {32{8'hEE}};
    wait_grant();
    tick();
    check("rst_mid_write_before", mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_async", mem_write, 1'b0);
    check("rst_mid_addr",        mem_address, '0);
    d_write = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_d_resp", d_resp, 1'b0);
    end

    // New I read after reset
    i_read = 1'b1; i_address = 32'h0000_0040;
    wait_grant();
    check("post_rst_i_addr", mem_address, 32'h0000_0040);
    respond(2, {32{8'h77}});
    check("post_rst_i_resp", i_resp, 1'b1);
    i_read = 1'b0;
    tick();

    // Contention: D wins first, I next, D wins the following pair
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    wait_grant();
    check("cont1_d_first", mem_address, 32'h0000_0200);
    respond(2, {32{8'h11}});
    check("cont1_d_resp", d_resp, 1'b1);
    check("cont1_i_wait", i_resp, 1'b0);
    d_read = 1'b0;
    tick();
    wait_grant();
    check("cont1_i_second", mem_address, 32'h0000_0100);
    respond(2, {32{8'h22}});
    check("cont1_i_resp",  i_resp, 1'b1);
    check("cont1_i_rdata", i_rdata, {32{8'h22}});
    i_read = 1'b0;
    tick();
    i_read = 1'b1; i_address = 32'h0000_0300;
    d_read = 1'b1; d_address = 32'h0000_0400;
    wait_grant();
    check("cont2_d_again", mem_address, 32'h0000_0400);
    respond(2, {32{8'h33}});
    d_read = 1'b0;
    tick();
    wait_grant();
    check("cont2_i_addr", mem_address, 32'h0000_0300);
    respond(4, {32{8'h44}});
    i_read = 1'b0;
    tick();

    // Simultaneous d_read and d_write: write dominates
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0800; d_wdata = {16{16'hBEEF}};
    wait_grant();
    check("rw_write", mem_write, 1'b1);
    check("rw_read",  mem_read, 1'b0);
    respond(2, {32{8'hC3}});
    check("rw_resp",  d_resp, 1'b1);
    check("rw_rdata_kept", d_rdata, {32{8'h33}});
    d_read = 1'b0; d_write = 1'b0;
    tick();

    // Stray mem_resp while idle
    mem_rdata = {32{8'hF0}}; mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    check("stray_i_resp", i_resp, 1'b0);
    check("stray_d_resp", d_resp, 1'b0);
    check("stray_strobe", mem_read | mem_write, 1'b0);
    tick();
    check("stray_i_rdata", i_rdata, {32{8'h44}});
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter between the instruction cache and data cache miss ports and the single shared cacheline port to physical memory.

- Grants one 256-bit line transaction at a time and forwards it to memory.
- Returns the line and a one-cycle response pulse to the winning cache. That pulse is the origin of the `instr_mem_resp`/`data_mem_resp` path the stall control unit consumes.
- Alternates grants under contention so neither port starves.

## Interface
Parameters:
- `ADDR_W`, 32: line address width (low 5 bits ignored, forwarded as 0)
- `LINE_W`, 256: cacheline width

Ports:
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `i_read`  in  1  I-cache line read request; held high until `i_resp`
- `i_address`  in  ADDR_W  I-cache line address
- `i_rdata`  out  LINE_W  line returned to I-cache
- `i_resp`  out  1  one-cycle completion pulse to I-cache
- `d_read`  in  1  D-cache line read request; held until `d_resp`
- `d_write`  in  1  D-cache line writeback request; held until `d_resp`
- `d_address`  in  ADDR_W  D-cache line address
- `d_wdata`  in  LINE_W  writeback line
- `d_rdata`  out  LINE_W  line returned to D-cache
- `d_resp`  out  1  one-cycle completion pulse to D-cache
- `mem_read`  out  1  memory read strobe, registered
- `mem_write`  out  1  memory write strobe, registered
- `mem_address`  out  ADDR_W  registered, low 5 bits zero
- `mem_wdata`  out  LINE_W  registered writeback data
- `mem_rdata`  in  LINE_W  memory read data, valid with `mem_resp`
- `mem_resp`  in  1  memory completion, one cycle

## Operation
FSM states: `IDLE`, `SERVE_I`, `SERVE_D`, `RESP_I`, `RESP_D`.

**IDLE**
- I requesting only (`i_read`): go to `SERVE_I`.
- D requesting only (`d_read|d_write`): go to `SERVE_D`.
- Both requesting: grant the port opposite `last_grant`, then update `last_grant`.
- `last_grant` resets to I, so D wins the first contention.
- On grant, register `mem_address`, `mem_wdata` and the strobe:
  - I grant: `mem_read`=1.
  - D grant: `mem_write`=`d_write`; `mem_read`=`d_read & ~d_write`. Write dominates if both are high; the simultaneous case is illegal but defined.

**SERVE_x**
- Hold strobes, address and data stable until `mem_resp`.
- On `mem_resp`:
  - capture `mem_rdata` into the x line buffer (write transactions leave the buffer unchanged);
  - clear both strobes;
  - go to `RESP_x`.

**RESP_x**
- Assert `x_resp`=1 for exactly one cycle.
- `x_rdata` is driven from the buffer; it holds its value until the next capture.
- Next state is `IDLE`. No grant is made in `RESP_x`; this gives the cache a cycle to drop its request.

**Other rules**
- A request dropped before its `resp` is illegal. The transaction still completes and `resp` still pulses.
- `mem_resp` arriving in `IDLE`/`RESP_x` is ignored.
- Async reset mid-transaction:
  - state→`IDLE`; strobes, resps, buffers and `mem_address`/`mem_wdata` go to 0; `last_grant`=I.
  - The in-flight transaction is abandoned; no `resp` is issued for it.

## Timing
- Reset values: all outputs 0.
- Request seen in `IDLE` at edge 0; `mem_read`/`mem_write` high from cycle 1.
- If `mem_resp` arrives in cycle N≥1, strobes are low in N+1 and `x_resp`=1 in N+1. The state is `IDLE` in N+2.
- Minimum request-to-resp latency: 2 cycles. Back-to-back grant gap: one `IDLE` cycle after `RESP`.
- A losing requester waits at most one full opposite transaction plus 2 cycles before its grant.
- `i_resp` and `d_resp` are never high in the same cycle. `mem_read` and `mem_write` are never both high.

## Test plan
- **Reset:** assert `rst_n`=0 mid-`SERVE_D` with `mem_write` high → `mem_write`=0 immediately (async); after release, `d_resp` never pulses; a new `i_read` is granted.
- **Single I miss:** `i_read`, `i_address`=0x0000_1234, memory 3-cycle latency, `mem_rdata`=0xA5…A5 → `mem_address`=0x0000_1220 from cycle 1, `i_resp` one pulse at cycle 4, `i_rdata`=0xA5…A5.
- **D writeback then read:** `d_write` with `d_wdata`=0x1…1, then `d_read` on the same line → `mem_write` only, then `mem_read` only; `d_rdata` unchanged after the write and updated after the read.
- **Contention after reset:** `i_read` and `d_read` both high → D served first, then I; next simultaneous pair → D again (alternation holds).
- **Simultaneous `d_read` & `d_write`:** → only `mem_write`=1. A stray `mem_resp` in `IDLE` → no resp, no state change.
